// File: rtl/dual_port_memory_responder.sv
// -----------------------------------------------------------------------------
// dual_port_memory_responder
//
// Memory-side responder for the datapath's two memory ports, sharing a single
// storage array. Each port runs its own IDLE -> BUSY -> RESP FSM so a request
// sampled at edge t completes with a one-cycle pulse from edge t+LATENCY.
//
// Ports
//   Clk          clock, all state changes on the rising edge
//   Reset_N      asynchronous reset, active-high (asserted = 1)
//   readM1       port-1 read request (level, held by the initiator)
//   address1     port-1 word address (upper bits above ADDR_BITS ignored)
//   data1        port-1 registered read data, holds its last value
//   inputReady1  port-1 completion pulse, data1 valid while high
//   readM2       port-2 read request (level)
//   writeM2      port-2 write request (level, wins over readM2)
//   address2     port-2 word address (upper bits above ADDR_BITS ignored)
//   data2        port-2 bidirectional data, driven here only in a read RESP
//   ack2         port-2 completion pulse for reads and writes
// -----------------------------------------------------------------------------
module dual_port_memory_responder #(
   parameter int WORD_SIZE = 16,
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 2
) (
   input  logic                 Clk,
   input  logic                 Reset_N,
   input  logic                 readM1,
   input  logic [WORD_SIZE-1:0] address1,
   output logic [WORD_SIZE-1:0] data1,
   output logic                 inputReady1,
   input  logic                 readM2,
   input  logic                 writeM2,
   input  logic [WORD_SIZE-1:0] address2,
   inout  wire  [WORD_SIZE-1:0] data2,
   output logic                 ack2
);

   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int DEPTH = 1 << ADDR_BITS;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   logic [WORD_SIZE-1:0] mem [DEPTH];

   state_t               st1, st1_nxt;
   logic [CNT_W-1:0]     cnt1, cnt1_nxt;
   logic                 take1, fire1;
   logic [ADDR_BITS-1:0] addr1_q;

   state_t               st2, st2_nxt;
   logic [CNT_W-1:0]     cnt2, cnt2_nxt;
   logic                 take2, fire2;
   logic [ADDR_BITS-1:0] addr2_q;
   logic                 wr2_q;
   logic [WORD_SIZE-1:0] wdata2_q;
   logic [WORD_SIZE-1:0] rdata2_q;

   // Address bits above ADDR_BITS wrap silently; collected here only so they
   // are visibly consumed.
   logic unused_addr_hi;
   assign unused_addr_hi = ^{address1[WORD_SIZE-1:ADDR_BITS], address2[WORD_SIZE-1:ADDR_BITS]};

   // ---------------- port 1 (read-only) ----------------
   always_comb begin
      st1_nxt  = st1;
      cnt1_nxt = cnt1;
      take1    = 1'b0;
      fire1    = 1'b0;
      case (st1)
         IDLE: begin
            if (readM1) begin
               st1_nxt  = BUSY;
               cnt1_nxt = CNT_LOAD;
               take1    = 1'b1;
            end
         end
         BUSY: begin
            if (cnt1 == '0) begin
               st1_nxt = RESP;
               fire1   = 1'b1;
            end else begin
               cnt1_nxt = cnt1 - 1'b1;
            end
         end
         RESP:    st1_nxt = IDLE;
         default: st1_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset_N) begin
      if (Reset_N) begin
         st1     <= IDLE;
         cnt1    <= '0;
         addr1_q <= '0;
         data1   <= '0;
      end else begin
         st1  <= st1_nxt;
         cnt1 <= cnt1_nxt;
         if (take1) addr1_q <= address1[ADDR_BITS-1:0];
         // Non-blocking read of mem gives read-before-write against port 2.
         if (fire1) data1 <= mem[addr1_q];
      end
   end

   assign inputReady1 = (st1 == RESP);

   // ---------------- port 2 (read/write) ----------------
   always_comb begin
      st2_nxt  = st2;
      cnt2_nxt = cnt2;
      take2    = 1'b0;
      fire2    = 1'b0;
      case (st2)
         IDLE: begin
            if (readM2 || writeM2) begin
               st2_nxt  = BUSY;
               cnt2_nxt = CNT_LOAD;
               take2    = 1'b1;
            end
         end
         BUSY: begin
            if (cnt2 == '0) begin
               st2_nxt = RESP;
               fire2   = 1'b1;
            end else begin
               cnt2_nxt = cnt2 - 1'b1;
            end
         end
         RESP:    st2_nxt = IDLE;
         default: st2_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset_N) begin
      if (Reset_N) begin
         st2      <= IDLE;
         cnt2     <= '0;
         addr2_q  <= '0;
         wr2_q    <= 1'b0;
         wdata2_q <= '0;
         rdata2_q <= '0;
      end else begin
         st2  <= st2_nxt;
         cnt2 <= cnt2_nxt;
         if (take2) begin
            addr2_q  <= address2[ADDR_BITS-1:0];
            wr2_q    <= writeM2;   // write wins when both requests are high
            wdata2_q <= data2;
         end
         if (fire2 && !wr2_q) rdata2_q <= mem[addr2_q];
      end
   end

   // Storage is never reset; an access dropped by reset never reaches here.
   always_ff @(posedge Clk) begin
      if (fire2 && wr2_q && !Reset_N) mem[addr2_q] <= wdata2_q;
   end

   assign ack2  = (st2 == RESP);
   assign data2 = (st2 == RESP && !wr2_q) ? rdata2_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_dual_port_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_dual_port_memory_responder
//
// Randomized scoreboard bench. Each round issues at most one access per port,
// with independent start offsets; the expected responses are computed from a
// word-array model at issue time and queued. A negedge monitor pops the queues
// whenever a completion pulse appears and also watches that the data2 bus is
// never driven by the block while the bench owns it.
// -----------------------------------------------------------------------------
module tb_dual_port_memory_responder;

   localparam int L = 2;

   typedef struct {
      int          due;
      bit          is_rd;
      logic [15:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        readM1;
   logic [15:0] address1;
   logic [15:0] data1;
   logic        inputReady1;
   logic        readM2;
   logic        writeM2;
   logic [15:0] address2;
   wire  [15:0] data2;
   logic        ack2;

   logic        tb_drv;
   logic [15:0] tb_val;
   assign data2 = tb_drv ? tb_val : 16'hzzzz;

   dual_port_memory_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(L)) dut (
      .Clk(clk), .Reset_N(rst),
      .readM1(readM1), .address1(address1), .data1(data1), .inputReady1(inputReady1),
      .readM2(readM2), .writeM2(writeM2), .address2(address2), .data2(data2), .ack2(ack2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] model [256];
   exp_t q1[$];
   exp_t q2[$];
   exp_t m1, m2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s at cycle %0d", name, cyc);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (inputReady1) begin
         if (q1.size() == 0) fail_now("p1_unexpected_pulse");
         else begin
            m1 = q1.pop_front();
            check("p1_latency", cyc, m1.due);
            check("p1_data", data1, m1.data);
         end
      end else if (q1.size() != 0 && q1[0].due < cyc) begin
         fail_now("p1_missing_pulse");
         void'(q1.pop_front());
      end

      if (ack2) begin
         if (q2.size() == 0) fail_now("p2_unexpected_ack");
         else begin
            m2 = q2.pop_front();
            check("p2_latency", cyc, m2.due);
            if (m2.is_rd) check("p2_read_data", data2, m2.data);
         end
      end else if (q2.size() != 0 && q2[0].due < cyc) begin
         fail_now("p2_missing_ack");
         void'(q2.pop_front());
      end

      if (tb_drv) check("data2_not_driven_by_block", data2, tb_val);
   end

   // ---------------- drivers ----------------
   task automatic p1_drive(input logic [15:0] a, input int d);
      repeat (d) begin @(negedge clk); #1; end
      readM1   = 1'b1;
      address1 = a;
      for (int i = 0; i < L + 8; i++) begin
         @(negedge clk);
         if (inputReady1) begin
            #1;
            readM1   = 1'b0;
            address1 = 16'($urandom);
            return;
         end
         #1;
         address1 = 16'($urandom);   // latched address must be used
      end
      fail_now("p1_handshake_timeout");
      readM1 = 1'b0;
   endtask

   task automatic p2_drive(input int op, input logic [15:0] a, input logic [15:0] wd,
                           input int d, input int due);
      repeat (d) begin @(negedge clk); #1; end
      readM2   = (op == 1 || op == 3);
      writeM2  = (op >= 2);
      address2 = a;
      tb_val   = (op >= 2) ? wd : 16'($urandom);
      tb_drv   = 1'b1;
      for (int i = 0; i < L + 8; i++) begin
         @(negedge clk);
         if (ack2) begin
            #1;
            readM2   = 1'b0;
            writeM2  = 1'b0;
            tb_drv   = 1'b1;
            tb_val   = 16'($urandom);
            return;
         end
         #1;
         address2 = 16'($urandom);
         tb_val   = 16'($urandom);
         if (op == 1 && cyc == due - 1) tb_drv = 1'b0;
      end
      fail_now("p2_handshake_timeout");
      readM2  = 1'b0;
      writeM2 = 1'b0;
      tb_drv  = 1'b1;
   endtask

   // op2: 0 none, 1 read, 2 write, 3 read+write (behaves as write)
   task automatic round(input bit r1, input logic [15:0] a1, input int d1,
                        input int op2, input logic [15:0] a2, input logic [15:0] wd, input int d2);
      int   c;
      bit   wr, done;
      exp_t e;
      @(negedge clk); #1;
      c    = cyc;
      wr   = (op2 >= 2);
      done = 1'b0;
      // A write completing strictly earlier than the port-1 read is visible to it;
      // on the same edge port 1 sees the old word.
      if (wr && (!r1 || d2 < d1)) begin
         model[a2[7:0]] = wd;
         done = 1'b1;
      end
      if (r1) begin
         e.due = c + d1 + 1 + L; e.is_rd = 1'b1; e.data = model[a1[7:0]];
         q1.push_back(e);
      end
      if (op2 == 1) begin
         e.due = c + d2 + 1 + L; e.is_rd = 1'b1; e.data = model[a2[7:0]];
         q2.push_back(e);
      end
      if (wr) begin
         e.due = c + d2 + 1 + L; e.is_rd = 1'b0; e.data = 16'h0;
         q2.push_back(e);
         if (!done) model[a2[7:0]] = wd;
      end
      fork
         if (r1) p1_drive(a1, d1);
         if (op2 != 0) p2_drive(op2, a2, wd, d2, c + d2 + 1 + L);
      join
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation did not finish");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] ra1, ra2;
      rst      = 1'b1;
      readM1   = 1'b0;
      readM2   = 1'b0;
      writeM2  = 1'b0;
      address1 = 16'h0;
      address2 = 16'h0;
      tb_drv   = 1'b1;
      tb_val   = 16'h0;

      repeat (3) @(negedge clk);
      check("reset_data1", data1, 16'h0);
      check("reset_inputReady1", inputReady1, 1'b0);
      check("reset_ack2", ack2, 1'b0);
      #1 rst = 1'b0;

      // give every word a known value
      for (int a = 0; a < 256; a++) round(1'b0, 16'h0, 0, 2, 16'(a), 16'($urandom), 0);

      // write then read back
      round(1'b0, 16'h0, 0, 2, 16'h0005, 16'h1234, 0);
      round(1'b1, 16'h0005, 0, 0, 16'h0, 16'h0, 0);

      // same-edge read/write collision, then both ports read the same word
      round(1'b0, 16'h0, 0, 2, 16'h0007, 16'hAAAA, 0);
      round(1'b1, 16'h0007, 0, 2, 16'h0007, 16'h5555, 0);
      round(1'b1, 16'h0007, 0, 1, 16'h0007, 16'h0, 0);

      // address wrap
      round(1'b0, 16'h0, 0, 2, 16'h0105, 16'hBEEF, 0);
      round(1'b1, 16'h0005, 0, 0, 16'h0, 16'h0, 0);

      // read and write both high -> write, bus never driven by the block
      round(1'b0, 16'h0, 0, 3, 16'h0003, 16'h00FF, 0);
      round(1'b1, 16'h0003, 0, 0, 16'h0, 16'h0, 0);

      // reset during a write's BUSY phase drops it
      round(1'b0, 16'h0, 0, 2, 16'h0009, 16'h0001, 0);
      @(negedge clk); #1;
      writeM2  = 1'b1;
      address2 = 16'h0009;
      tb_val   = 16'hDEAD;
      @(negedge clk); #1;
      rst     = 1'b1;
      writeM2 = 1'b0;
      #1;
      check("async_reset_ack2", ack2, 1'b0);
      check("async_reset_data1", data1, 16'h0);
      check("async_reset_inputReady1", inputReady1, 1'b0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      repeat (4) @(negedge clk);
      round(1'b1, 16'h0009, 0, 1, 16'h0009, 16'h0, 0);

      // randomized mix with independent start offsets
      for (int n = 0; n < 300; n++) begin
         ra1 = 16'($urandom);
         ra2 = 16'($urandom);
         if ($urandom_range(1, 0) == 1) begin
            ra1[7:0] = 8'($urandom_range(3, 0));
            ra2[7:0] = 8'($urandom_range(3, 0));
         end
         round(1'($urandom_range(1, 0)), ra1, $urandom_range(2, 0),
               $urandom_range(3, 0), ra2, 16'($urandom), $urandom_range(2, 0));
      end

      repeat (L + 4) @(negedge clk);
      check("p1_queue_drained", q1.size(), 0);
      check("p2_queue_drained", q2.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
